pkt_to_msg_scheduler: RTL
=========================

// Module: pkt_to_msg_scheduler
// PURPOSE
//  Round-robin scheduler between the input port's per-VC flit buffers and the message queue.
//  Picks one VC holding a complete packet and drives the r_pkt_to_msg/g_pkt_to_msg handshake.
//  Steers the input-port output mux via sel_vc_o; pulses free_vc_o so the VC buffer is released.
//  Sits between input_port (router side) and the message-queue interface.
// PARAMETERS
//  N_OF_VC         2                        VCs per virtual network
//  N_OF_VN         2                        virtual networks
//  N_TOT_OF_VC     N_OF_VC*N_OF_VN (4)      total VC buffers; VC index = vn*N_OF_VC + vc
//  N_BITS_POINTER  clog2(N_TOT_OF_VC) (2)   width of the VC pointer
// PORTS
//  clk              in   1               clock, all state on posedge
//  rst              in   1               asynchronous active-low reset (0 = reset)
//  pkt_ready_i      in   N_TOT_OF_VC     level; bit i = VC i holds a complete packet
//  r_pkt_to_msg_o   out  1               request to the message queue, registered
//  g_pkt_to_msg_i   in   1               grant from the message queue, sampled on posedge
//  sel_vc_o         out  N_BITS_POINTER  selected VC for the out_link mux, registered
//  free_vc_o        out  N_TOT_OF_VC     one-hot, 1-cycle pulse; releases VC buffer i
//  busy_o           out  1               1 when state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr_ptr=0, last_freed mask=0, r=0, sel_vc_o=0, free=0, busy=0.
//  FSM states: IDLE, REQ, FREE.
//   IDLE: elig = pkt_ready_i & ~mask. Mask = one-hot of the VC freed in the previous cycle,
//    else 0. If elig!=0 at edge k: winner = first set bit searching rr_ptr, rr_ptr+1, ... mod N.
//    Then sel_vc_o<=winner, r<=1, ->REQ. Request is visible in cycle k+1 (1-cycle latency).
//   REQ: r and sel_vc_o held stable.
//    g_pkt_to_msg_i=1 at edge: ->FREE; r<=0; free_vc_o<=onehot(sel); rr_ptr<=sel+1 mod N_TOT_OF_VC.
//    pkt_ready_i[sel] low at edge with g=0: abort; ->IDLE, r<=0, no free pulse, rr_ptr unchanged.
//    If g=1 and ready drops at the same edge, the grant wins.
//   FREE: free_vc_o high exactly this cycle; mask<=onehot(sel); ->IDLE; free<=0 next edge.
//  g_pkt_to_msg_i outside REQ is ignored.
//  Packet throughput is at most 1 per 3 cycles (IDLE, REQ, FREE).
//  rr_ptr wraps from N_TOT_OF_VC-1 to 0. Increment is done in N_BITS_POINTER+1 bits, then reduced mod N.
//  This keeps non-power-of-2 N correct.
//  sel_vc_o keeps its last value in IDLE/FREE; only meaningful while r=1.
//  Reset asserted mid-REQ/FREE drops r/free immediately. No packet is freed and the buffer stays intact.
// CONFIGURATION
//  PKT_SCHED_VN_PRIORITY_EN defined:
//   Strict priority to the highest VN index that has an eligible VC.
//   Inside that VN, round-robin with a per-VN pointer (N_OF_VN pointers, each reset 0).
//   Only the granted VN's pointer advances.
//  Undefined: single round-robin over all N_TOT_OF_VC VCs, as above.
//  Ports are identical in both builds.
// TESTING
//  1 reset: rst=0 asynchronously while in REQ on VC2 -> r=0, sel=0, free=0, busy=0 before next edge.
//  2 single: ready=4'b0001; g=1 on 3rd REQ cycle -> sel=0, r high 3 cycles, free=4'b0001 1 cycle,
//    then IDLE.
//  3 RR: ready=4'b1111 held, g=1 always -> grants 0,1,2,3,0; a new r every 3 cycles.
//  4 wrap/mask: last grant VC3, ready=4'b1001 -> grant VC0.
//    Single VC, ready=4'b0001 held after free -> re-grant only after 1 masked IDLE cycle.
//  5 abort/spurious: ready=4'b0100 then ready=0 before g -> r falls next cycle, free=0, rr_ptr=0.
//    Then ready=4'b0110 -> grant VC1.
//    g=1 in IDLE with ready=0 -> no free pulse, stays IDLE.
//  6 macro: PKT_SCHED_VN_PRIORITY_EN, ready=4'b0111 -> first grant VC2 (VN1), then VC0, then VC1.
//    Without the macro -> 0,1,2.

Source files
------------

// File: rtl/pkt_to_msg_scheduler.sv
// Round-robin pick of a VC holding a complete packet, handed to the message queue over r/g.
// Latency: request registered 1 cycle after eligibility; IDLE->REQ->FREE gives at most 1 packet per 3 cycles.
// Backpressure: request and sel_vc_o hold until grant; withdrawn if the packet vanishes. PKT_SCHED_VN_PRIORITY_EN adds VN priority.
module pkt_to_msg_scheduler #(
   parameter int N_OF_VC        = 2,
   parameter int N_OF_VN        = 2,
   parameter int N_TOT_OF_VC    = N_OF_VC * N_OF_VN,
   parameter int N_BITS_POINTER = $clog2(N_TOT_OF_VC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_TOT_OF_VC-1:0]    pkt_ready_i,
   output logic                      r_pkt_to_msg_o,
   input  logic                      g_pkt_to_msg_i,
   output logic [N_BITS_POINTER-1:0] sel_vc_o,
   output logic [N_TOT_OF_VC-1:0]    free_vc_o,
   output logic                      busy_o
);

   typedef enum logic [1:0] {IDLE, REQ, FREE} state_t;

   state_t                      state_q, state_d;
   logic                        r_q, r_d;
   logic [N_BITS_POINTER-1:0]   sel_q, sel_d;
   logic [N_TOT_OF_VC-1:0]      free_q, free_d;
   logic [N_TOT_OF_VC-1:0]      mask_q, mask_d;
   logic [N_TOT_OF_VC-1:0]      elig;
   logic [N_TOT_OF_VC-1:0]      sel_onehot;
   logic [N_BITS_POINTER-1:0]   win;

   assign elig       = pkt_ready_i & ~mask_q;
   assign sel_onehot = N_TOT_OF_VC'(1) << sel_q;

`ifdef PKT_SCHED_VN_PRIORITY_EN
   localparam int VC_W = (N_OF_VC > 1) ? $clog2(N_OF_VC) : 1;

   logic [VC_W-1:0] vn_ptr_q [N_OF_VN];
   logic [VC_W-1:0] vn_ptr_d [N_OF_VN];

   // Highest VN is scanned first, so the first hit is the strict-priority winner.
   always_comb begin
      logic                      found;
      logic [N_BITS_POINTER-1:0] idx;
      int                        c;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      c     = 0;
      for (int v = N_OF_VN - 1; v >= 0; v--) begin
         for (int i = 0; i < N_OF_VC; i++) begin
            c   = (int'(vn_ptr_q[v]) + i) % N_OF_VC;
            idx = N_BITS_POINTER'(v * N_OF_VC + c);
            if (!found && elig[idx]) begin
               found = 1'b1;
               win   = idx;
            end
         end
      end
   end
`else
   logic [N_BITS_POINTER-1:0] rr_ptr_q, rr_ptr_d;
   logic [N_BITS_POINTER:0]   ptr_inc;

   always_comb begin
      logic                      found;
      logic [N_BITS_POINTER-1:0] idx;
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < N_TOT_OF_VC; i++) begin
         idx = N_BITS_POINTER'((int'(rr_ptr_q) + i) % N_TOT_OF_VC);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // One extra bit so the wrap is exact for non-power-of-2 VC counts.
   assign ptr_inc = {1'b0, sel_q} + (N_BITS_POINTER+1)'(1);
`endif

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      sel_d   = sel_q;
      free_d  = '0;
      mask_d  = '0;
`ifdef PKT_SCHED_VN_PRIORITY_EN
      vn_ptr_d = vn_ptr_q;
`else
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|elig) begin
               sel_d   = win;
               r_d     = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (g_pkt_to_msg_i) begin
               state_d = FREE;
               r_d     = 1'b0;
               free_d  = sel_onehot;
`ifdef PKT_SCHED_VN_PRIORITY_EN
               for (int v = 0; v < N_OF_VN; v++) begin
                  if (v == int'(sel_q) / N_OF_VC)
                     vn_ptr_d[v] = VC_W'((int'(sel_q) % N_OF_VC + 1) % N_OF_VC);
               end
`else
               if (ptr_inc >= (N_BITS_POINTER+1)'(N_TOT_OF_VC))
                  rr_ptr_d = '0;
               else
                  rr_ptr_d = ptr_inc[N_BITS_POINTER-1:0];
`endif
            end else if (!pkt_ready_i[sel_q]) begin
               state_d = IDLE;
               r_d     = 1'b0;
            end
         end
         FREE: begin
            // The freed buffer may still show ready this cycle; keep it out of the next pick.
            mask_d  = sel_onehot;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         r_q     <= 1'b0;
         sel_q   <= '0;
         free_q  <= '0;
         mask_q  <= '0;
`ifdef PKT_SCHED_VN_PRIORITY_EN
         for (int v = 0; v < N_OF_VN; v++) vn_ptr_q[v] <= '0;
`else
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         sel_q   <= sel_d;
         free_q  <= free_d;
         mask_q  <= mask_d;
`ifdef PKT_SCHED_VN_PRIORITY_EN
         vn_ptr_q <= vn_ptr_d;
`else
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   assign r_pkt_to_msg_o = r_q;
   assign sel_vc_o       = sel_q;
   assign free_vc_o      = free_q;
   assign busy_o         = (state_q != IDLE);

endmodule
